// File: rtl/kb_matrix_scan.sv
// kb_matrix_scan: keypad column scanner with whole-frame debounce, single-key decode and hex entry register.
module kb_matrix_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  K_ROW,
    output logic [3:0]  K_COL,
    output logic [4:0]  key_code,
    output logic        key_strobe,
    output logic        key_held,
    output logic [15:0] hex_out
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    typedef enum logic {IDLE, HELD} state_t;
    state_t          state, state_next;
    logic [SW-1:0]   scan_cnt;
    logic [1:0]      col;
    logic [19:0]     frame;
    logic            frame_done;
    logic [4:0]      nlow, idx;
    logic [5:0]      cand, prev_cand;
    logic [CW-1:0]   stab_cnt, stab_next;
    logic            tick, stable, acc, acc_q;
    logic [4:0]      acc_code;
    assign tick = scan_cnt == SW'(SCAN_DIV - 1);
    // cand is {valid, code}; 0 means no key or a ghosted multi-key frame
    always_comb begin
        nlow = '0;
        idx  = '0;
        for (int i = 0; i < 20; i++) begin
            if (!frame[i]) begin
                nlow = nlow + 5'd1;
                idx  = 5'(i);
            end
        end
        cand      = nlow == 5'd1 ? {1'b1, idx} : 6'd0;
        stab_next = cand != prev_cand ? CW'(1) :
                    stab_cnt == CW'(DEBOUNCE_CNT) ? stab_cnt : stab_cnt + CW'(1);
        stable    = frame_done && stab_next == CW'(DEBOUNCE_CNT);
    end
    always_comb begin
        state_next = state;
        acc        = 1'b0;
        if (stable) begin
            if (state == IDLE && cand[5]) begin
                state_next = HELD;
                acc        = 1'b1;
            end else if (state == HELD && !cand[5]) begin
                state_next = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            col        <= '0;
            K_COL      <= 4'b1110;
            frame      <= '1;
            frame_done <= 1'b0;
            prev_cand  <= '0;
            stab_cnt   <= '0;
            state      <= IDLE;
            acc_q      <= 1'b0;
            acc_code   <= '0;
            key_code   <= '0;
            key_strobe <= 1'b0;
            key_held   <= 1'b0;
            hex_out    <= '0;
        end else begin
            scan_cnt   <= tick ? '0 : scan_cnt + SW'(1);
            frame_done <= tick && col == 2'd3;
            if (tick) begin
                col   <= col + 2'd1;
                K_COL <= {K_COL[2:0], K_COL[3]};
                for (int r = 0; r < 5; r++) frame[r*4 + int'(col)] <= K_ROW[r];
            end
            if (frame_done) begin
                stab_cnt  <= stab_next;
                prev_cand <= cand;
            end
            state <= state_next;
            acc_q <= acc;
            if (acc) acc_code <= cand[4:0];
            // second stage gives the two-cycle strobe latency after the last column sample
            key_strobe <= acc_q;
            key_held   <= state == HELD;
            if (acc_q) begin
                key_code <= acc_code;
                hex_out  <= acc_code < 5'd16 ? {hex_out[11:0], acc_code[3:0]} :
                            acc_code == 5'd16 ? 16'h0000 :
                            acc_code == 5'd17 ? {4'h0, hex_out[15:4]} : hex_out;
            end
        end
    end
endmodule

// File: doc/kb_matrix_scan.md
Name: kb_matrix_scan

Overview:
- Keypad front end of the Lab2 keyboard/display datapath.
- Drives keypad column lines, samples the 5 row inputs, and debounces the whole frame.
- Decodes a single pressed key into a 5-bit code and emits a one-cycle strobe per debounced press.
- Maintains a 4-digit hex entry register that feeds the 7-segment Display module's Hexs input directly.

Parameters:
- SCAN_DIV, 50000, clk cycles each column stays driven; must be ≥ 2.
- DEBOUNCE_CNT, 4, consecutive identical frames required to accept a press or a release; must be ≥ 1.

Ports:
- clk  input  1  system clock (clk_100mhz domain).
- rst_n  input  1  synchronous reset, active-low.
- K_ROW  input  5  keypad rows; active-low; externally pulled up.
- K_COL  output  4  keypad column drive; active-low, exactly one bit low.
- key_code  output  5  code of the last accepted key: row*4+col, range 0..19.
- key_strobe  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high while the accepted key remains debounced-pressed.
- hex_out  output  16  hex entry register; connects to Display Hexs.

Behaviour:
- Reset (rst_n low at a clk edge) sets: K_COL=4'b1110, column index 0, scan counter 0, frame register all 1s, key_code=0, key_strobe=0, key_held=0, hex_out=16'h0000, debounce counter 0, FSM=IDLE.
- Reset mid-frame or mid-debounce discards all partial state; scanning restarts at column 0.
- Scan counter runs 0..SCAN_DIV-1.
- When the counter is at SCAN_DIV-1: latch K_ROW into the frame slot for the current column, then advance the column (3 wraps to 0). K_COL rotates {K_COL[2:0],K_COL[3]} on the same edge.
- Sampling column 3 completes a frame; frame_done pulses high for the next cycle.
- Frame evaluation happens on the frame_done cycle:
  - Exactly one bit of the 20-bit frame low → cand = {valid=1, row*4+col}.
  - Zero bits low or ≥2 bits low (ghosting) → cand = NONE.
- Debounce: if cand equals the previous frame's cand, the stable counter increments, saturating at DEBOUNCE_CNT; otherwise it resets to 1. prev_cand is then updated.
- FSM, evaluated only on frame_done cycles:
  - IDLE: stable cand is a key with count==DEBOUNCE_CNT → HELD. On that transition: key_code<=code, key_strobe=1 for exactly the next cycle, key_held<=1.
  - HELD: stable cand is NONE with count==DEBOUNCE_CNT → IDLE, key_held<=0.
  - HELD: a stable different single key with count==DEBOUNCE_CNT → no strobe. The FSM must pass through IDLE first; a release is required between accepted presses.
- Strobe latency: key_strobe rises exactly 2 cycles after the sampling edge of column 3 of the accepting frame.
- hex_out updates in the same cycle key_strobe is high:
  - code 0..15 → hex_out <= {hex_out[11:0], code[3:0]}; the oldest digit is discarded (wrap-around by shift-out).
  - code 16 (CLR) → hex_out <= 0.
  - code 17 (BKSP) → hex_out <= {4'h0, hex_out[15:4]}.
  - code 18/19 → strobe and key_code only; hex_out unchanged.
- key_code holds its value until the next accepted press; it is not cleared on release.
- All outputs are registered; no combinational path from K_ROW to any output.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3; one frame = 16 cycles.)
- Reset: hold rst_n=0 for 3 cycles, K_ROW=5'h1F → K_COL=4'b1110, hex_out=0, key_strobe=0, key_held=0. After release, K_COL rotates every 4 cycles: 1110→1101→1011→0111→1110.
- Single press: K_ROW[1] low only while K_COL=1101 (code 5) for 5 frames → exactly one key_strobe, 2 cycles after column-3 sampling of frame 3. Then key_code=5, key_held=1, hex_out=16'h0005.
- Bounce rejection: key 5 pressed frames 1–2, released frame 3, pressed frames 4–6 → single strobe, at the end of frame 6. No strobe before that.
- Entry and wrap: sequential clean presses of keys 1,2,3,4,9 with releases between → hex_out=16'h2349.
- Ghosting and function keys: two keys held at once for 5 frames → no strobe. Code 17 with hex_out=16'hABCD → 16'h0ABC. Code 16 → 16'h0000.
- Reset mid-debounce: assert rst_n=0 during frame 2 of a press, then keep the key held → strobe only after 3 full post-reset frames.
